// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions: receiver state encoding, bit-time helper and the
// line idle level (also used by the transmitter side).
// ---------------------------------------------------------------------------
package uart_pkg;

  // Receiver FSM states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_rx_state_t;

  // Level of an idle (marking) serial line
  localparam logic UART_IDLE = 1'b1;

  // Number of system clocks per serial bit (integer division)
  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/sync2.sv
// ---------------------------------------------------------------------------
// sync2
// Generic two-flop synchronizer for a single asynchronous bit.
// Ports:
//   clk   - destination clock
//   rst   - asynchronous active-low reset, both flops load RST_VAL
//   i_d   - asynchronous input
//   o_q   - synchronized output
// ---------------------------------------------------------------------------
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_core.sv
// ---------------------------------------------------------------------------
// uart_rx_core
// 8N1 UART receiver. Oversamples the asynchronous line on clk, samples each
// bit at its centre and delivers good characters as a registered byte plus a
// one-cycle interrupt strobe. Frames with a low stop bit are reported through
// frame_err and never delivered as data.
// Ports:
//   clk       - system clock, rising edge
//   rst       - asynchronous active-low reset
//   uart_rx   - raw serial line, idle high
//   rx_irq    - one-cycle pulse, new byte on rx_byte
//   rx_byte   - last good character, held until the next good frame
//   frame_err - one-cycle pulse, stop bit sampled low
//   rx_busy   - high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int SYS_CLK_FREQ = 100000000,
  parameter int BAUD         = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic       rx_irq,
  output logic [7:0] rx_byte,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(SYS_CLK_FREQ, BAUD);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (CLKS_PER_BIT < 8) begin : g_bad_rate
    $error("uart_rx_core: SYS_CLK_FREQ/BAUD must be at least 8");
  end

  uart_rx_state_t   r_state;
  uart_rx_state_t   w_next_state;
  logic             w_rxs;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [7:0]       r_sh;
  logic [7:0]       r_rx_byte;
  logic             r_rx_irq;
  logic             r_frame_err;
  logic             r_rx_busy;

  logic             w_cnt_half;
  logic             w_cnt_full;
  logic             w_cnt_clr;
  logic             w_idx_clr;
  logic             w_bit_take;
  logic             w_irq_set;
  logic             w_ferr_set;

  // Reset value is the idle level so reset release never fakes a start bit
  sync2 #(
    .RST_VAL (UART_IDLE)
  ) u_sync2 (
    .clk (clk),
    .rst (rst),
    .i_d (uart_rx),
    .o_q (w_rxs)
  );

  assign w_cnt_half = (r_cnt == CNT_HALF);
  assign w_cnt_full = (r_cnt == CNT_FULL);

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_rxs == 1'b0) begin
          w_next_state = START;
        end else begin
          w_next_state = IDLE;
        end
      end
      START: begin
        // A start bit that is high again at mid-bit is a glitch
        if (w_cnt_half) begin
          w_next_state = w_rxs ? IDLE : DATA;
        end else begin
          w_next_state = START;
        end
      end
      DATA: begin
        if (w_cnt_full && (r_idx == 3'd7)) begin
          w_next_state = STOP;
        end else begin
          w_next_state = DATA;
        end
      end
      STOP: begin
        // Leave at the stop-bit centre so a back-to-back start is not missed
        if (w_cnt_full) begin
          w_next_state = w_rxs ? IDLE : BREAK;
        end else begin
          w_next_state = STOP;
        end
      end
      BREAK: begin
        if (w_rxs == 1'b1) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = BREAK;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // FSM outputs: datapath controls and strobe requests
  always_comb begin
    w_cnt_clr  = 1'b0;
    w_idx_clr  = 1'b0;
    w_bit_take = 1'b0;
    w_irq_set  = 1'b0;
    w_ferr_set = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_clr = 1'b1;
      end
      START: begin
        w_cnt_clr = w_cnt_half;
        w_idx_clr = w_cnt_half;
      end
      DATA: begin
        w_cnt_clr  = w_cnt_full;
        w_bit_take = w_cnt_full;
      end
      STOP: begin
        w_cnt_clr  = w_cnt_full;
        w_irq_set  = w_cnt_full & w_rxs;
        w_ferr_set = w_cnt_full & ~w_rxs;
      end
      BREAK: begin
        w_cnt_clr = 1'b1;
      end
      default: begin
        w_cnt_clr = 1'b1;
      end
    endcase
  end

  // Datapath: bit timer, bit index, shift register and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_idx       <= 3'd0;
      r_sh        <= 8'h00;
      r_rx_byte   <= 8'h00;
      r_rx_irq    <= 1'b0;
      r_frame_err <= 1'b0;
      r_rx_busy   <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_clr ? '0 : (r_cnt + CNT_ONE);
      r_rx_irq    <= w_irq_set;
      r_frame_err <= w_ferr_set;
      r_rx_busy   <= (w_next_state != IDLE);
      if (w_idx_clr) begin
        r_idx <= 3'd0;
      end else if (w_bit_take) begin
        r_idx <= r_idx + 3'd1;
      end
      // LSB arrives first, so new bits enter at the top and move right
      if (w_bit_take) begin
        r_sh <= {w_rxs, r_sh[7:1]};
      end
      if (w_irq_set) begin
        r_rx_byte <= r_sh;
      end
    end
  end

  assign rx_irq    = r_rx_irq;
  assign frame_err = r_frame_err;
  assign rx_byte   = r_rx_byte;
  assign rx_busy   = r_rx_busy;

endmodule

// File: tb/tb_uart_rx_core.sv
module tb_uart_rx_core;

  localparam int CPB  = 10;   // 1 MHz / 100 kbaud
  localparam int HALF = 5;
  localparam int LAT  = 2 + HALF + 9 * CPB + 1;  // pin fall -> strobe cycle

  logic       clk;
  logic       rst;
  logic       uart_rx;
  logic       rx_irq;
  logic [7:0] rx_byte;
  logic       frame_err;
  logic       rx_busy;

  typedef struct {
    bit         is_irq;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       exp_q[$];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] last_good = 8'h00;
  logic       prev_pulse = 1'b0;

  uart_rx_core #(
    .SYS_CLK_FREQ (1000000),
    .BAUD         (100000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .rx_irq    (rx_irq),
    .rx_byte   (rx_byte),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every strobe must match the oldest expectation
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (rx_irq || frame_err) begin
        chk("irq_ferr_exclusive", {31'd0, rx_irq & frame_err}, 32'd0);
        chk("pulse_one_cycle", {31'd0, prev_pulse}, 32'd0);
        chk("pulse_expected", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("pulse_kind_irq", {31'd0, rx_irq}, {31'd0, e.is_irq});
          chk("rx_byte", {24'd0, rx_byte}, {24'd0, e.data});
          chk("pulse_cycle", cyc, e.cyc);
        end
      end
      prev_pulse = rx_irq | frame_err;
    end else begin
      prev_pulse = 1'b0;
    end
  end

  // Hold the line at v for n cycles (called at a negedge, returns at a negedge)
  task automatic line_for(input logic v, input int n);
    uart_rx = v;
    repeat (n) @(negedge clk);
  endtask

  // One 8N1 frame; the reference model predicts the outcome from its content
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int gap);
    exp_t e;
    e.is_irq = stop_bit;
    e.cyc    = cyc + LAT;
    if (stop_bit) begin
      last_good = b;
    end
    e.data = last_good;
    exp_q.push_back(e);
    line_for(1'b0, CPB);
    for (int i = 0; i < 8; i++) begin
      line_for(b[i], CPB);
    end
    line_for(stop_bit, CPB);
    if (gap > 0) begin
      line_for(1'b1, gap);
    end
  endtask

  initial begin
    int         c;
    logic [7:0] b;
    logic       sb;
    int         g;
    logic [7:0] v55;

    rst     = 1'b0;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_rx_byte", {24'd0, rx_byte}, 32'h00);
    chk("reset_rx_irq", {31'd0, rx_irq}, 32'd0);
    chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
    chk("reset_rx_busy", {31'd0, rx_busy}, 32'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Good frame
    send_frame(8'h2D, 1'b1, 20);

    // Glitch: 3-cycle low pulse
    c = cyc;
    line_for(1'b0, 3);
    line_for(1'b1, 4);
    chk("glitch_busy_T0p5", {31'd0, rx_busy}, 32'd1);
    @(negedge clk);
    chk("glitch_busy_T0p6", {31'd0, rx_busy}, 32'd0);
    chk("glitch_cycle_ref", cyc - c, 32'd8);
    line_for(1'b1, 20);

    // Bad stop bit, line stays low until released
    send_frame(8'h70, 1'b0, 0);
    chk("break_busy_high", {31'd0, rx_busy}, 32'd1);
    line_for(1'b1, 5);
    chk("break_back_idle", {31'd0, rx_busy}, 32'd0);
    chk("bad_stop_keeps_byte", {24'd0, rx_byte}, 32'h2D);
    line_for(1'b1, 15);

    // Back-to-back frames, one stop bit each
    send_frame(8'h2D, 1'b1, 0);
    send_frame(8'h70, 1'b1, 20);

    // Reset in the middle of data bit 4 of 0x55
    v55 = 8'h55;
    line_for(1'b0, CPB);
    for (int i = 0; i < 4; i++) begin
      line_for(v55[i], CPB);
    end
    line_for(v55[4], 5);
    rst     = 1'b0;
    uart_rx = 1'b1;
    last_good = 8'h00;
    repeat (3) @(negedge clk);
    chk("midframe_reset_byte", {24'd0, rx_byte}, 32'h00);
    chk("midframe_reset_busy", {31'd0, rx_busy}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("after_reset_byte", {24'd0, rx_byte}, 32'h00);
    repeat (5) @(negedge clk);
    send_frame(8'h5F, 1'b1, 20);

    // Held-low break: one frame error, nothing else
    begin
      exp_t e;
      e.is_irq = 1'b0;
      e.data   = last_good;
      e.cyc    = cyc + LAT;
      exp_q.push_back(e);
    end
    line_for(1'b0, 300);
    chk("break300_busy", {31'd0, rx_busy}, 32'd1);
    line_for(1'b1, 10);
    chk("break300_idle", {31'd0, rx_busy}, 32'd0);
    send_frame(8'h41, 1'b1, 20);

    // Randomized frames
    for (int k = 0; k < 40; k++) begin
      b  = 8'($urandom);
      sb = ($urandom_range(0, 3) != 0);
      g  = sb ? $urandom_range(0, 15) : $urandom_range(3, 15);
      send_frame(b, sb, g);
    end

    line_for(1'b1, 200);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    chk("final_byte", {24'd0, rx_byte}, {24'd0, last_good});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

UART receiver for the SoC's console/bootloader path: oversamples the asynchronous `uart_rx` pin on the system clock and deframes 8N1 characters. It produces a registered byte plus a one-cycle `rx_irq` strobe. This is the exact `uart_rx_irq`/`uart_rx_byte` pair consumed by the program-loader control stage and the UART Wishbone peripheral. Framing errors are flagged, never delivered as data.

## Interface
- `SYS_CLK_FREQ`, 100000000: system clock frequency in Hz.
- `BAUD`, 115200: line rate in bit/s.
- Derived constant `CLKS_PER_BIT = SYS_CLK_FREQ / BAUD` (integer division, 868 at defaults). Elaboration error if < 8.
- Derived constant `HALF_BIT = CLKS_PER_BIT / 2`.
- `clk` input 1: system clock, all logic on rising edge.
- `rst` input 1: reset rst, asynchronous, active-low; clock clk.
- `uart_rx` input 1: raw asynchronous serial line, idle high.
- `rx_irq` output 1: one-cycle pulse, new valid byte on `rx_byte`.
- `rx_byte` output 8: last good character, held until the next good stop bit.
- `frame_err` output 1: one-cycle pulse, stop bit sampled low.
- `rx_busy` output 1: high in every state except IDLE.

## Operation
- Input synchronizer: 2 flops, both reset to 1 so reset release never looks like a start bit. Core logic sees only the synchronized `rxs`.
- Bit-time counter `cnt` has width clog2(CLKS_PER_BIT). Bit index `idx` is 3 bits. Shift register `sh` is 8 bits and shifts right, so LSB is received first.
- FSM states and transitions:
  - IDLE: when `rxs`=0, clear `cnt` and go to START.
  - START: when `cnt`=HALF_BIT-1, sample `rxs`. If 0, clear `cnt` and `idx` and go to DATA. If 1, treat it as a glitch and return to IDLE with no output.
  - DATA: when `cnt`=CLKS_PER_BIT-1, sample `rxs` into `sh[7]` with a right shift, then clear `cnt`. After `idx`=7 is sampled, go to STOP; otherwise increment `idx`.
  - STOP: when `cnt`=CLKS_PER_BIT-1, sample `rxs`.
    - If 1: load `rx_byte`←`sh`, pulse `rx_irq` next cycle, go to IDLE. The remaining half stop bit is not waited out, so back-to-back frames are accepted.
    - If 0: pulse `frame_err` next cycle, leave `rx_byte` unchanged, go to BREAK.
  - BREAK: stay until `rxs`=1, then go to IDLE. A held-low line therefore yields exactly one `frame_err` and no further activity.
- `rx_irq` and `frame_err` are mutually exclusive and never asserted for more than 1 cycle.
- No receive FIFO. The consumer must take `rx_byte` on the `rx_irq` cycle or before the next `rx_irq`; older data is overwritten silently.

## Timing
- Reset values: state IDLE, `rx_irq`=0, `frame_err`=0, `rx_busy`=0, `rx_byte`=8'h00, `sh`=0, `cnt`=0, `idx`=0.
- Let T0 be the first cycle `rxs`=0 in IDLE, which is 2 cycles after the pin falls.
- START transition is registered at T0, so `rx_busy` is high from T0+1.
- Start bit is sampled at T0+HALF_BIT.
- Data bit i is sampled at T0+HALF_BIT+(i+1)·CLKS_PER_BIT.
- Stop bit is sampled at T0+HALF_BIT+9·CLKS_PER_BIT.
- `rx_irq`/`frame_err` are high, and `rx_byte` shows the new value, in cycle T0+HALF_BIT+9·CLKS_PER_BIT+1. `rx_busy` is low in that same cycle.
- A new start edge seen in the cycle after the STOP sample is accepted normally.
- Async reset mid-frame: all state is cleared immediately, and no `rx_irq` or `frame_err` is emitted for the aborted frame. If the line is low at reset release, the synchronizer needs 2 cycles before START can be entered.

## Structure
- Shared package `uart_pkg` holds:
  - the `uart_rx_state_t` enum (IDLE, START, DATA, STOP, BREAK);
  - a `clks_per_bit(freq, baud)` function;
  - the line-idle constant `UART_IDLE = 1'b1`, which the future uart_tx will reuse.
- One sub-module, `sync2`: a generic 2-flop synchronizer with parameterized reset value, instanced once here.

## Test plan
Bench parameters: SYS_CLK_FREQ=1000000, BAUD=100000, so CLKS_PER_BIT=10 and HALF_BIT=5.
- Send 0x2D with a valid stop bit → exactly one `rx_irq` at T0+96, `rx_byte`=8'h2D, `frame_err` never high.
- Start pulse low for 3 cycles, then high → no `rx_irq`, no `frame_err`, `rx_busy` back low at T0+6.
- Send 0x70 with stop bit 0, then line high → `frame_err` pulse at T0+96, `rx_byte` keeps its previous value 8'h2D, state returns to IDLE once the line is high.
- Send 0x2D then 0x70 back-to-back with exactly 1 stop bit each → two `rx_irq` pulses 100 cycles apart with bytes 8'h2D then 8'h70.
- Assert `rst` at bit 4 of 0x55, then release, then send 0x5F → no output for 0x55; `rx_byte`=8'h00 right after reset; then one `rx_irq` with 8'h5F.
- Hold line low for 300 cycles (break) → exactly one `frame_err` and zero `rx_irq`; a following 0x41 frame is received correctly.
